// File: rtl/rcon_round_ctrl_if.sv
// Handshake and memory-port bundle between the RCON sequencer, the RCON memory
// and the key-expansion datapath.
interface rcon_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              start;
   logic              rcon_ready;
   logic [DATA_W-1:0] mem_out;
   logic [DATA_W-1:0] mem_in;
   logic              mem_wr_en;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] rcon;
   logic              rcon_valid;
   logic [3:0]        round;
   logic              init_done;
   logic              busy;
   logic              done;

   modport master (
      input  start, rcon_ready, mem_out,
      output mem_in, mem_wr_en, mem_rd_en, mem_addr,
             rcon, rcon_valid, round, init_done, busy, done
   );

   modport slave (
      output start, rcon_ready, mem_out,
      input  mem_in, mem_wr_en, mem_rd_en, mem_addr,
             rcon, rcon_valid, round, init_done, busy, done
   );
endinterface

// File: rtl/rcon_round_ctrl.sv
// AES-128 RCON sequencer: fills the round-constant memory after reset, then
// streams one constant per round to the key-expansion datapath on start.
module rcon_round_ctrl #(
   parameter int NUM_ROUNDS = 10,
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8
) (
   input  logic   clk,
   input  logic   rst,
   rcon_if.master bus
);
   localparam int CNT_W = 5;

   typedef enum logic [2:0] {
      S_INIT, S_INIT_END, S_IDLE, S_RD, S_WAIT, S_HOLD
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [7:0]        r_g;
   logic [DATA_W-1:0] r_mem_in;
   logic              r_wr_en;
   logic              r_rd_en;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_rcon;
   logic              r_valid;
   logic [CNT_W-1:0]  r_round;
   logic              r_init_done;
   logic              r_busy;
   logic              r_done;

   function automatic logic [7:0] xtime(input logic [7:0] g);
      return {g[6:0], 1'b0} ^ (g[7] ? 8'h1b : 8'h00);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_INIT;
         r_cnt       <= '0;
         r_g         <= 8'h01;
         r_mem_in    <= '0;
         r_wr_en     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_addr      <= '0;
         r_rcon      <= '0;
         r_valid     <= 1'b0;
         r_round     <= '0;
         r_init_done <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_INIT: begin
               r_wr_en  <= 1'b1;
               r_addr   <= ADDR_W'(r_cnt);
               r_mem_in <= DATA_W'(r_g);
               r_cnt    <= r_cnt + 1'b1;
               r_g      <= xtime(r_g);
               if (r_cnt == CNT_W'(NUM_ROUNDS - 1)) r_state <= S_INIT_END;
            end
            S_INIT_END: begin
               r_wr_en     <= 1'b0;
               r_init_done <= 1'b1;
               r_state     <= S_IDLE;
            end
            S_IDLE: begin
               if (bus.start) begin
                  r_rd_en <= 1'b1;
                  r_addr  <= '0;
                  r_busy  <= 1'b1;
                  r_round <= CNT_W'(1);
                  r_state <= S_RD;
               end
            end
            S_RD: begin
               r_rd_en <= 1'b0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_rcon  <= bus.mem_out;
               r_valid <= 1'b1;
               r_state <= S_HOLD;
            end
            S_HOLD: begin
               if (bus.rcon_ready) begin
                  r_valid <= 1'b0;
                  if (r_round == CNT_W'(NUM_ROUNDS)) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_round <= '0;
                     r_state <= S_IDLE;
                  end else begin
                     // round is 1-based, so its current value is the next table index
                     r_round <= r_round + 1'b1;
                     r_rd_en <= 1'b1;
                     r_addr  <= ADDR_W'(r_round);
                     r_state <= S_RD;
                  end
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

   assign bus.mem_in     = r_mem_in;
   assign bus.mem_wr_en  = r_wr_en;
   assign bus.mem_rd_en  = r_rd_en;
   assign bus.mem_addr   = r_addr;
   assign bus.rcon       = r_rcon;
   assign bus.rcon_valid = r_valid;
   assign bus.round      = r_round[3:0];
   assign bus.init_done  = r_init_done;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
endmodule
